segre_mem_arbiter: RTL and testbench

Single-port memory arbiter and sequencer between instruction fetch (IF) and the data memory operation issued by the MEM stage from the EX/MEM `memop_*` fields. It serialises both requesters onto one word-wide memory port with fixed data-over-fetch priority. It generates byte enables and write-lane alignment for sub-word stores and drops stale fetch responses when EX reports a taken branch/jump (`tkbr`).

---
 rtl/segre_mem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_segre_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_mem_arbiter.sv
// Single-port memory arbiter: serialises instruction fetch and MEM-stage data
// accesses onto one word-wide memory port. Data has priority over fetch.
// It also generates byte enables and store-lane replication, and discards a
// fetch response when a taken branch/jump arrives while that fetch is in flight.

package segre_pkg;
    localparam int WORD_SIZE = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } memop_data_type_e;
endpackage

// FSM states
//   state   | meaning
//   IDLE    | no access in flight; grants are issued only here
//   DM_BUSY | data access presented on the memory port, waiting mem_ready_i
//   IF_BUSY | fetch presented on the memory port, waiting mem_ready_i
module segre_mem_arbiter #(
    parameter int WORD_SIZE = segre_pkg::WORD_SIZE
) (
    input  logic                         clk_i,
    input  logic                         rsn_i,
    // instruction fetch
    input  logic                         if_req_i,
    input  logic [WORD_SIZE-1:0]         if_addr_i,
    output logic                         if_gnt_o,
    output logic                         if_rvalid_o,
    output logic [WORD_SIZE-1:0]         if_rdata_o,
    input  logic                         tkbr_i,
    // data access
    input  logic                         dm_req_i,
    input  logic                         dm_we_i,
    input  segre_pkg::memop_data_type_e  dm_type_i,
    input  logic [WORD_SIZE-1:0]         dm_addr_i,
    input  logic [WORD_SIZE-1:0]         dm_wdata_i,
    output logic                         dm_gnt_o,
    output logic                         dm_misaligned_o,
    output logic                         dm_rvalid_o,
    output logic [WORD_SIZE-1:0]         dm_rdata_o,
    // memory port
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [3:0]                   mem_be_o,
    output logic [WORD_SIZE-1:0]         mem_addr_o,
    output logic [WORD_SIZE-1:0]         mem_wdata_o,
    input  logic                         mem_ready_i,
    input  logic [WORD_SIZE-1:0]         mem_rdata_i
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DM_BUSY = 2'd1;
    localparam logic [1:0] IF_BUSY = 2'd2;

    localparam logic [WORD_SIZE-1:0] WORD_MASK = ~WORD_SIZE'(3);

    logic [1:0]           state_q,     state_d;
    logic                 mem_req_q,   mem_req_d;
    logic                 mem_we_q,    mem_we_d;
    logic [3:0]           mem_be_q,    mem_be_d;
    logic [WORD_SIZE-1:0] mem_addr_q,  mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD_SIZE-1:0] rdata_q,     rdata_d;
    logic                 if_rvalid_q, if_rvalid_d;
    logic                 dm_rvalid_q, dm_rvalid_d;
    logic                 dm_mis_q,    dm_mis_d;
    logic                 kill_q,      kill_d;

    logic [1:0]           dm_off;
    logic [3:0]           dm_be;
    logic [WORD_SIZE-1:0] dm_wdata_al;
    logic                 dm_mis;
    logic                 idle;
    logic                 dm_gnt;
    logic                 if_gnt;

    assign dm_off = dm_addr_i[1:0];
    assign idle   = (state_q == IDLE);

    // Byte-enable generation, store-lane replication and alignment check
    always_comb begin
        dm_be       = 4'b1111;
        dm_wdata_al = dm_wdata_i;
        dm_mis      = 1'b0;
        case (dm_type_i)
            segre_pkg::MEM_BYTE: begin
                dm_be       = 4'b0001 << dm_off;
                dm_wdata_al = {(WORD_SIZE/8){dm_wdata_i[7:0]}};
            end
            segre_pkg::MEM_HALF: begin
                dm_be       = 4'b0011 << dm_off;
                dm_wdata_al = {(WORD_SIZE/16){dm_wdata_i[15:0]}};
                dm_mis      = dm_off[0];
            end
            default: begin
                dm_mis = (dm_off != 2'b00);
            end
        endcase
    end

    // Grants: IDLE only, data first; a fetch in a taken-branch cycle is refused.
    // Gated by reset so nothing is granted while the block is held in reset.
    always_comb begin
        dm_gnt = rsn_i && idle && dm_req_i && !dm_mis;
        if_gnt = rsn_i && idle && !dm_req_i && if_req_i && !tkbr_i;
    end

    assign dm_gnt_o = dm_gnt;
    assign if_gnt_o = if_gnt;

    // Next-state logic for the sequencer and the memory-port registers
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        kill_d      = kill_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        dm_mis_d    = 1'b0;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (dm_req_i && dm_mis) begin
                    // The requester still holds dm_req_i in the pulse cycle;
                    // do not report the same rejected access twice.
                    dm_mis_d = !dm_mis_q;
                end else if (dm_gnt) begin
                    state_d     = DM_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr_i & WORD_MASK;
                    mem_wdata_d = dm_wdata_al;
                end else if (if_gnt) begin
                    state_d     = IF_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'b1111;
                    mem_addr_d  = if_addr_i & WORD_MASK;
                    mem_wdata_d = '0;
                end
            end
            DM_BUSY: begin
                if (mem_ready_i) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    rdata_d     = mem_rdata_i;
                    dm_rvalid_d = 1'b1;
                end
            end
            IF_BUSY: begin
                if (tkbr_i) begin
                    kill_d = 1'b1;
                end
                if (mem_ready_i) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    rdata_d     = mem_rdata_i;
                    if_rvalid_d = !(kill_q || tkbr_i);
                    kill_d      = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rsn_i
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            dm_mis_q    <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            dm_mis_q    <= dm_mis_d;
            kill_q      <= kill_d;
        end
    end

    assign mem_req_o       = mem_req_q;
    assign mem_we_o        = mem_we_q;
    assign mem_be_o        = mem_be_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign if_rvalid_o     = if_rvalid_q;
    assign if_rdata_o      = rdata_q;
    assign dm_rvalid_o     = dm_rvalid_q;
    assign dm_rdata_o      = rdata_q;
    assign dm_misaligned_o = dm_mis_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter: table of data accesses plus
// hand-written sequences for priority, fetch kill and mid-access reset.
module tb_segre_mem_arbiter;
    import segre_pkg::*;

    logic             clk_i = 1'b0;
    logic             rsn_i = 1'b0;
    logic             if_req_i = 1'b0;
    logic [31:0]      if_addr_i = '0;
    logic             if_gnt_o, if_rvalid_o;
    logic [31:0]      if_rdata_o;
    logic             tkbr_i = 1'b0;
    logic             dm_req_i = 1'b0;
    logic             dm_we_i = 1'b0;
    memop_data_type_e dm_type_i = MEM_WORD;
    logic [31:0]      dm_addr_i = '0;
    logic [31:0]      dm_wdata_i = '0;
    logic             dm_gnt_o, dm_misaligned_o, dm_rvalid_o;
    logic [31:0]      dm_rdata_o;
    logic             mem_req_o, mem_we_o;
    logic [3:0]       mem_be_o;
    logic [31:0]      mem_addr_o, mem_wdata_o;
    logic             mem_ready_i = 1'b0;
    logic [31:0]      mem_rdata_i = '0;

    segre_mem_arbiter #(.WORD_SIZE(32)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .tkbr_i(tkbr_i),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_type_i(dm_type_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_misaligned_o(dm_misaligned_o), .dm_rvalid_o(dm_rvalid_o),
        .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             we;
        memop_data_type_e typ;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [31:0]      rdata;
        int               lat;
        logic [3:0]       be;
        logic [31:0]      mwdata;
        logic [31:0]      maddr;
        logic             mis;
    } vec_t;

    vec_t vecs[9];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge, outputs sampled on the falling edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic dm_access(input vec_t v, input int id);
        step();
        dm_req_i    = 1'b1;
        dm_we_i     = v.we;
        dm_type_i   = v.typ;
        dm_addr_i   = v.addr;
        dm_wdata_i  = v.wdata;
        mem_rdata_i = v.rdata;
        smp();
        chk($sformatf("v%0d dm_gnt", id), 32'(dm_gnt_o), 32'(!v.mis));
        chk($sformatf("v%0d if_gnt", id), 32'(if_gnt_o), 32'd0);
        step();
        dm_req_i = 1'b0;
        if (v.mis) begin
            smp();
            chk($sformatf("v%0d misaligned", id), 32'(dm_misaligned_o), 32'd1);
            chk($sformatf("v%0d mem_req", id), 32'(mem_req_o), 32'd0);
            step();
            smp();
            chk($sformatf("v%0d misaligned end", id), 32'(dm_misaligned_o), 32'd0);
            chk($sformatf("v%0d no rvalid", id), 32'(dm_rvalid_o), 32'd0);
            chk($sformatf("v%0d mem_req idle", id), 32'(mem_req_o), 32'd0);
        end else begin
            for (int k = 0; k <= v.lat; k++) begin
                if (k > 0) step();
                mem_ready_i = (k == v.lat);
                smp();
                chk($sformatf("v%0d mem_req c%0d", id, k), 32'(mem_req_o), 32'd1);
                chk($sformatf("v%0d early rvalid c%0d", id, k), 32'(dm_rvalid_o), 32'd0);
                chk($sformatf("v%0d be c%0d", id, k), 32'(mem_be_o), 32'(v.be));
                chk($sformatf("v%0d addr c%0d", id, k), mem_addr_o, v.maddr);
                if (k == 0) begin
                    chk($sformatf("v%0d wdata", id), mem_wdata_o, v.mwdata);
                    chk($sformatf("v%0d we", id), 32'(mem_we_o), 32'(v.we));
                end
            end
            step();
            mem_ready_i = 1'b0;
            smp();
            chk($sformatf("v%0d dm_rvalid", id), 32'(dm_rvalid_o), 32'd1);
            chk($sformatf("v%0d dm_rdata", id), dm_rdata_o, v.rdata);
            chk($sformatf("v%0d mem_req drop", id), 32'(mem_req_o), 32'd0);
            chk($sformatf("v%0d if_rvalid", id), 32'(if_rvalid_o), 32'd0);
            step();
            smp();
            chk($sformatf("v%0d rvalid pulse", id), 32'(dm_rvalid_o), 32'd0);
        end
    endtask

    initial begin
        //          we    type      addr         wdata         rdata        L  be       mwdata        maddr        mis
        vecs[0] = '{1'b0, MEM_WORD, 32'h00000100, 32'h00000000, 32'hDEADBEEF, 2, 4'b1111, 32'h00000000, 32'h00000100, 1'b0};
        vecs[1] = '{1'b1, MEM_BYTE, 32'h00000203, 32'h000000A5, 32'h11112222, 0, 4'b1000, 32'hA5A5A5A5, 32'h00000200, 1'b0};
        vecs[2] = '{1'b1, MEM_HALF, 32'h00000102, 32'h0000BEEF, 32'h33334444, 1, 4'b1100, 32'hBEEFBEEF, 32'h00000100, 1'b0};
        vecs[3] = '{1'b0, MEM_HALF, 32'h00000101, 32'h00000000, 32'h55556666, 0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1};
        vecs[4] = '{1'b0, MEM_BYTE, 32'h00000001, 32'h12345678, 32'h0A0B0C0D, 0, 4'b0010, 32'h78787878, 32'h00000000, 1'b0};
        vecs[5] = '{1'b1, MEM_WORD, 32'h00000202, 32'h01020304, 32'h77778888, 0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1};
        vecs[6] = '{1'b0, MEM_HALF, 32'h00000100, 32'h00000000, 32'h9999AAAA, 0, 4'b0011, 32'h00000000, 32'h00000100, 1'b0};
        vecs[7] = '{1'b1, MEM_WORD, 32'h000003FC, 32'hCAFEF00D, 32'hBBBBCCCC, 1, 4'b1111, 32'hCAFEF00D, 32'h000003FC, 1'b0};
        vecs[8] = '{1'b1, MEM_BYTE, 32'h00000302, 32'h0000005A, 32'hDDDDEEEE, 3, 4'b0100, 32'h5A5A5A5A, 32'h00000300, 1'b0};

        // reset: everything quiet even with requests pending
        if_req_i  = 1'b1;
        if_addr_i = 32'h00000040;
        dm_req_i  = 1'b1;
        #12;
        chk("rst if_gnt", 32'(if_gnt_o), 32'd0);
        chk("rst dm_gnt", 32'(dm_gnt_o), 32'd0);
        chk("rst mem_req", 32'(mem_req_o), 32'd0);
        chk("rst mem_be", 32'(mem_be_o), 32'd0);
        chk("rst mem_addr", mem_addr_o, 32'd0);
        chk("rst rvalids", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);
        chk("rst misaligned", 32'(dm_misaligned_o), 32'd0);
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        step();
        rsn_i = 1'b1;
        step();
        smp();
        chk("post-rst mem_req", 32'(mem_req_o), 32'd0);

        for (int i = 0; i < 9; i++) dm_access(vecs[i], i);

        // simultaneous requests: data first, fetch granted with the data rvalid
        step();
        dm_req_i  = 1'b1; dm_we_i = 1'b0; dm_type_i = MEM_WORD; dm_addr_i = 32'h10;
        if_req_i  = 1'b1; if_addr_i = 32'h400;
        smp();
        chk("prio dm_gnt", 32'(dm_gnt_o), 32'd1);
        chk("prio if_gnt", 32'(if_gnt_o), 32'd0);
        step();
        dm_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'hAAAA5555;
        smp();
        chk("prio if_gnt busy", 32'(if_gnt_o), 32'd0);
        chk("prio first addr", mem_addr_o, 32'h10);
        step();
        mem_ready_i = 1'b0;
        smp();
        chk("prio dm_rvalid", 32'(dm_rvalid_o), 32'd1);
        chk("prio dm_rdata", dm_rdata_o, 32'hAAAA5555);
        chk("prio if_gnt now", 32'(if_gnt_o), 32'd1);
        step();
        if_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h00000013;
        smp();
        chk("prio fetch addr", mem_addr_o, 32'h400);
        chk("prio fetch be", 32'(mem_be_o), 32'hF);
        chk("prio fetch we", 32'(mem_we_o), 32'd0);
        step();
        mem_ready_i = 1'b0;
        smp();
        chk("prio if_rvalid", 32'(if_rvalid_o), 32'd1);
        chk("prio if_rdata", if_rdata_o, 32'h00000013);

        // fetch in a tkbr cycle refused; then fetch killed mid-flight (L=3)
        step();
        if_req_i = 1'b1; if_addr_i = 32'h502; tkbr_i = 1'b1;
        smp();
        chk("tkbr same-cycle if_gnt", 32'(if_gnt_o), 32'd0);
        step();
        tkbr_i = 1'b0;
        smp();
        chk("kill if_gnt", 32'(if_gnt_o), 32'd1);
        step();
        if_req_i = 1'b0;
        smp();
        chk("kill mem_req", 32'(mem_req_o), 32'd1);
        chk("kill addr", mem_addr_o, 32'h500);
        step();
        tkbr_i = 1'b1;
        smp();
        step();
        tkbr_i = 1'b0;
        smp();
        chk("kill busy", 32'(mem_req_o), 32'd1);
        step();
        mem_ready_i = 1'b1; mem_rdata_i = 32'h00000077;
        smp();
        step();
        mem_ready_i = 1'b0;
        smp();
        chk("kill no if_rvalid", 32'(if_rvalid_o), 32'd0);
        chk("kill mem_req drop", 32'(mem_req_o), 32'd0);
        step();
        smp();
        chk("kill no late rvalid", 32'(if_rvalid_o), 32'd0);

        // new PC fetch after the kill returns normally
        step();
        if_req_i = 1'b1; if_addr_i = 32'h600;
        smp();
        chk("newpc if_gnt", 32'(if_gnt_o), 32'd1);
        step();
        if_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h00100093;
        smp();
        chk("newpc addr", mem_addr_o, 32'h600);
        step();
        mem_ready_i = 1'b0;
        smp();
        chk("newpc if_rvalid", 32'(if_rvalid_o), 32'd1);
        chk("newpc if_rdata", if_rdata_o, 32'h00100093);

        // tkbr arriving in the completion cycle still kills
        step();
        if_req_i = 1'b1; if_addr_i = 32'h700;
        smp();
        chk("late-kill if_gnt", 32'(if_gnt_o), 32'd1);
        step();
        if_req_i = 1'b0; mem_ready_i = 1'b1; tkbr_i = 1'b1;
        smp();
        step();
        mem_ready_i = 1'b0; tkbr_i = 1'b0;
        smp();
        chk("late-kill if_rvalid", 32'(if_rvalid_o), 32'd0);

        // reset during DM_BUSY clears outputs at once; re-issued access served
        step();
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_type_i = MEM_WORD; dm_addr_i = 32'h80;
        smp();
        chk("midrst dm_gnt", 32'(dm_gnt_o), 32'd1);
        step();
        dm_req_i = 1'b0;
        smp();
        chk("midrst mem_req before", 32'(mem_req_o), 32'd1);
        #1 rsn_i = 1'b0;
        #1;
        chk("midrst mem_req", 32'(mem_req_o), 32'd0);
        chk("midrst mem_be", 32'(mem_be_o), 32'd0);
        chk("midrst mem_addr", mem_addr_o, 32'd0);
        step();
        step();
        rsn_i = 1'b1;
        smp();
        chk("midrst idle", 32'(mem_req_o), 32'd0);
        dm_access('{1'b0, MEM_WORD, 32'h00000080, 32'h0, 32'h5555AAAA, 1, 4'b1111, 32'h0, 32'h00000080, 1'b0}, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
